// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: one 16-bit adder swept LSW-first over
// NUM_WORDS slices, carry chained through a register.

module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        overflow
);

    // overflow is the carry out of bit 15
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'b0, cin};

endmodule

module wide_add_sequencer #(
    parameter int NUM_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start,
    input  logic [16*NUM_WORDS-1:0] a_in,
    input  logic [16*NUM_WORDS-1:0] b_in,
    input  logic                    carry_in,
    output logic                    busy,
    output logic                    done,
    output logic [16*NUM_WORDS-1:0] result,
    output logic                    carry_out
);

    localparam int W  = 16 * NUM_WORDS;
    localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_sr;
    logic [W-1:0]    b_sr;
    logic [W-1:0]    psum;
    logic [W-1:0]    psum_nx;
    logic            carry_r;
    logic [CW-1:0]   cnt;
    logic            last;
    logic [15:0]     slice_sum;
    logic            slice_co;

    adder_16bit u_add (
        .a        (a_sr[15:0]),
        .b        (b_sr[15:0]),
        .cin      (carry_r),
        .sum      (slice_sum),
        .overflow (slice_co)
    );

    assign last    = (cnt == CW'(NUM_WORDS - 1));
    assign psum_nx = {slice_sum, psum[W-1:16]};

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nx;
    end

    // next state and handshake outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: if (start) state_nx = ADD;
            ADD: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // operand capture, slice shifting and result load
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            psum      <= '0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a_in;
                        b_sr    <= b_in;
                        carry_r <= carry_in;
                        cnt     <= '0;
                    end
                end
                ADD: begin
                    psum    <= psum_nx;
                    carry_r <= slice_co;
                    a_sr    <= a_sr >> 16;
                    b_sr    <= b_sr >> 16;
                    cnt     <= cnt + CW'(1);
                    if (last) begin
                        result    <= psum_nx;
                        carry_out <= slice_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Randomised bench for wide_add_sequencer against a
// timeline model of the add (W+1-bit arithmetic).

module tb_wide_add_sequencer;

    localparam int N = 4;
    localparam int W = 16 * N;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    int n_pass = 0;
    int n_total = 0;

    wide_add_sequencer #(.NUM_WORDS(N)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: phase = cycles since the accepting edge (0 = idle).
    int           phase = 0;
    logic [W:0]   pend = '0;
    logic [W:0]   exp_out = '0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase   = 0;
            pend    = '0;
            exp_out = '0;
        end else if (phase == 0) begin
            if (start) begin
                pend  = {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, carry_in};
                phase = 1;
            end
        end else if (phase == N + 1) begin
            phase = 0;
        end else begin
            phase = phase + 1;
            if (phase == N + 1) exp_out = pend;
        end
    end

    // Compare process
    int cyc = 0;
    bit gap_mode = 0;
    int last_done = -1;

    always @(negedge clk) begin
        cyc++;
        check("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, (phase >= 1 && phase <= N)});
        check("done", {{W{1'b0}}, done}, {{W{1'b0}}, (phase == N + 1)});
        check("result", {1'b0, result}, {1'b0, exp_out[W-1:0]});
        check("carry_out", {{W{1'b0}}, carry_out}, {{W{1'b0}}, exp_out[W]});
        if (gap_mode && done) begin
            if (last_done >= 0) check("done_gap", (W+1)'(cyc - last_done), (W+1)'(N + 2));
            last_done = cyc;
        end
    end

    // Drive one op from an idle cycle; measure latency and busy span.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit lit, input logic [W-1:0] er, input logic ec);
        int lat;
        int nb;
        lat = -1;
        nb = 0;
        @(negedge clk);
        start = 1'b1;
        a_in = a;
        b_in = b;
        carry_in = c;
        @(negedge clk);
        start = 1'b0;
        a_in = W'({$urandom, $urandom});
        b_in = W'({$urandom, $urandom});
        carry_in = 1'($urandom);
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            if (busy) nb++;
            if (done) begin
                lat = i;
                break;
            end
        end
        if (lit) begin
            check("latency", (W+1)'(lat), (W+1)'(N + 1));
            check("busy_len", (W+1)'(nb), (W+1)'(N));
            check("lit_result", {1'b0, result}, {1'b0, er});
            check("lit_carry", {{W{1'b0}}, carry_out}, {{W{1'b0}}, ec});
        end else if (lat < 0) begin
            check("done_timeout", (W+1)'(lat), (W+1)'(N + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("rst_result", {1'b0, result}, '0);
        check("rst_busy", {{W{1'b0}}, busy}, '0);
        @(negedge clk);
        #2 n_rst = 1'b1;

        // plain sum
        run_op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b0,
               1, 64'h0011_0022_0033_0044, 1'b0);
        // full carry ripple
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1, 64'h0, 1'b1);
        // slice-boundary carry
        run_op(64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001, 1'b0,
               1, 64'h0000_0000_0001_0000, 1'b0);

        // reset mid-add after two ADD cycles
        @(negedge clk);
        start = 1'b1;
        a_in = 64'h1111_2222_3333_4444;
        b_in = 64'h1;
        carry_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_result", {1'b0, result}, '0);
        check("mid_rst_carry", {{W{1'b0}}, carry_out}, '0);
        check("mid_rst_busy", {{W{1'b0}}, busy}, '0);
        check("mid_rst_done", {{W{1'b0}}, done}, '0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        repeat (10) @(negedge clk);

        // start held high with changing operands
        last_done = -1;
        gap_mode = 1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 4 * (N + 2) + 2; i++) begin
            a_in = W'({$urandom, $urandom});
            b_in = W'({$urandom, $urandom});
            carry_in = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (N + 3) @(negedge clk);
        gap_mode = 0;

        // randomised operands, with extreme values mixed in
        for (int k = 0; k < 1000; k++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'({$urandom, $urandom});
            b = W'({$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = '1;
            run_op(a, b, 1'($urandom), 0, '0, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder built around one shared adder_16bit instance: sequences it over NUM_WORDS 16-bit slices, LSW first, chaining the carry through a register.
- Gives the design a 16*NUM_WORDS-bit add at the area cost of one 16-bit adder.
- Start/busy/done handshake toward an upstream controller; result and carry held stable until the next accepted start.
- adder_16bit's overflow output is its carry-out of bit 15 and is used as such here.

Parameters:
- NUM_WORDS, 4, number of 16-bit slices; operand width W = 16*NUM_WORDS; legal range 2..16.

Ports:
- clk  input  1  system clock, all state on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  request a new add; sampled on clk only in IDLE.
- a_in  input  W  operand A; sampled in the cycle start is accepted.
- b_in  input  W  operand B; sampled with a_in.
- carry_in  input  1  carry into slice 0; sampled with a_in.
- busy  output  1  high while slices are being added (ADD state).
- done  output  1  one-cycle pulse: result/carry_out just became valid.
- result  output  W  registered sum, held until the next done.
- carry_out  output  1  registered carry out of the MS slice, held with result.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, n_rst).
- Reset (n_rst=0, any time, including mid-operation):
  - State goes to IDLE; slice counter = 0.
  - Internal operand, partial-sum and carry registers are cleared.
  - busy=0, done=0, result=0, carry_out=0.
  - Any operation in flight is abandoned; there is no resume.
- States: IDLE, ADD, DONE.
- IDLE:
  - start=1 at an edge → capture a_in, b_in into shift registers, carry_in into the carry register, counter=0, go to ADD.
  - start=0 → stay in IDLE.
- ADD (busy=1):
  - Each cycle the adder sees the low 16 bits of the A/B shift registers plus the carry register.
  - At the edge: sum enters the partial-sum register from the top (shift right 16), the adder carry-out loads the carry register, operands shift right 16, counter increments.
  - When counter == NUM_WORDS-1 at the edge → load result from the assembled partial sum (including this last slice), load carry_out from the final carry, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then unconditionally return to IDLE.
- start is ignored in ADD and DONE; it is not queued. Back-to-back throughput is one add per NUM_WORDS+2 cycles.
- Latency: start accepted at edge k → busy high for cycles k+1..k+NUM_WORDS, done high in cycle k+NUM_WORDS+1. result/carry_out change only at the edge entering DONE.
- Arithmetic: unsigned modulo 2^W; carry_out is the true bit W of A+B+carry_in. No signed-overflow flag.
- Operand changes on a_in/b_in/carry_in after capture have no effect on the operation in flight.
- Counter width: clog2(NUM_WORDS); no wrap is exercised because exit occurs at NUM_WORDS-1.

Test Plan (NUM_WORDS=4):
1. Reset mid-add: start with A=0x1111_2222_3333_4444, B=1, drop n_rst after 2 ADD cycles → outputs immediately 0, state IDLE, no done pulse afterward.
2. Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=0, carry_in=1 → done in cycle k+5, result=0, carry_out=1; busy high exactly 4 cycles.
3. Plain sum: A=0x0001_0002_0003_0004, B=0x0010_0020_0030_0040, carry_in=0 → result=0x0011_0022_0033_0044, carry_out=0.
4. Slice-boundary carry: A=0x0000_0000_0000_FFFF, B=0x0000_0000_0000_0001 → result=0x0000_0000_0001_0000, carry_out=0.
5. Start while busy: assert start continuously with changing operands → only the first op runs; its result is unaffected; the next op is accepted in the IDLE cycle after done; done pulses are exactly 6 cycles apart.
6. Randomized check: 1000 random A/B/carry_in against a 65-bit reference model; result and carry_out hold stable between done pulses.
